// File: rtl/pmodda4_pkg.sv
// Shared types and constants for the PmodDA4 sample feeder.
package pmodda4_pkg;

  localparam int unsigned SAMPLE_W = 12;
  localparam logic [SAMPLE_W-1:0] DAC_MIDSCALE = 12'h800;

  // Feeder playback state encoding
  typedef enum logic [1:0] {
    stWAIT    = 2'd0,
    stRUN     = 2'd1,
    stSTARVED = 2'd2
  } feeder_state_t;

  // Single-cycle rising-edge detect from current and previous sample
  function automatic logic rise_detect(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/pmodda4_sample_fifo.sv
// Synchronous show-ahead FIFO holding DAC samples; head is the oldest entry.
module pmodda4_sample_fifo
  import pmodda4_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned W     = SAMPLE_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];
  assign level   = count;

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pmodda4_sample_feeder.sv
// Paced sample source for the PmodDA4 controller: buffers producer samples and
// updates the held DAC value once every rate_div+1 SYNC frames.
// Optional build macro PMODDA4_FEEDER_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module pmodda4_sample_feeder
  import pmodda4_pkg::*;
#(
  parameter int unsigned          DEPTH       = 16,
  parameter int unsigned          AW          = 4,
  parameter int unsigned          START_LEVEL = 4,
  parameter logic [SAMPLE_W-1:0]  RESET_VALUE = DAC_MIDSCALE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  input  logic [SAMPLE_W-1:0] s_data,
  output logic                s_ready,
  input  logic [15:0]         rate_div,
  input  logic                sync,
  input  logic                underrun_clr,
  output logic [SAMPLE_W-1:0] value,
  output logic                frame_tick,
  output logic [AW:0]         level,
  output logic                underrun
`ifdef PMODDA4_FEEDER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]         underrun_cnt
`endif
);

  feeder_state_t       state_q;
  feeder_state_t       state_d;
  logic [15:0]         fcnt_q;
  logic [15:0]         fcnt_d;
  logic                sync_q;
  logic                boundary;
  logic                pace;
  logic                start_ok;
  logic                pop;
  logic                starve;
  logic                push;
  logic                fifo_full;
  logic                fifo_empty;
  logic [SAMPLE_W-1:0] head;

  assign boundary = rise_detect(sync, sync_q);
  assign pace     = (fcnt_q >= rate_div);
  assign start_ok = (level >= (AW+1)'(START_LEVEL));
  assign push     = s_valid & s_ready;
  assign s_ready  = ~fifo_full;

  pmodda4_sample_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (SAMPLE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (s_data),
    .pop       (pop),
    .head      (head),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State, frame counter and SYNC history registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= stWAIT;
      fcnt_q  <= '0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      sync_q  <= sync;
    end
  end

  // Playback sequencing: pacing, pop decision and starvation detect
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    pop     = 1'b0;
    starve  = 1'b0;
    case (state_q)
      stWAIT, stSTARVED: begin
        fcnt_d = '0;
        if (start_ok) state_d = stRUN;
      end
      stRUN: begin
        if (boundary) begin
          if (pace) begin
            fcnt_d = '0;
            if (!fifo_empty) begin
              pop = 1'b1;
            end else begin
              starve  = 1'b1;
              state_d = stSTARVED;
            end
          end else begin
            fcnt_d = fcnt_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = stWAIT;
        fcnt_d  = '0;
      end
    endcase
  end

  // Held DAC value, frame pulse and sticky underrun flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      value      <= RESET_VALUE;
      frame_tick <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_tick <= boundary;
      if (pop) value <= head;
      if (starve)            underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
    end
  end

`ifdef PMODDA4_FEEDER_UNDERRUN_CNT_EN
  // Saturating count of starvation events; an increment beats a clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      underrun_cnt <= '0;
    end else if (starve) begin
      if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
    end else if (underrun_clr) begin
      underrun_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_pmodda4_sample_feeder.sv
// Scoreboard bench for pmodda4_sample_feeder: pushed samples are queued as the
// expected value sequence; a monitor compares every change of value against it.
module tb_pmodda4_sample_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [11:0] s_data;
  logic        s_ready;
  logic [15:0] rate_div;
  logic        sync;
  logic        underrun_clr;
  logic [11:0] value;
  logic        frame_tick;
  logic [4:0]  level;
  logic        underrun;
`ifdef PMODDA4_FEEDER_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [11:0] exp_q[$];

  pmodda4_sample_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .rate_div     (rate_div),
    .sync         (sync),
    .underrun_clr (underrun_clr),
    .value        (value),
    .frame_tick   (frame_tick),
    .level        (level),
    .underrun     (underrun)
`ifdef PMODDA4_FEEDER_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a sample and wait (bounded) until it is accepted
  task automatic push(input logic [11:0] d);
    int unsigned waited = 0;
    bit ok = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!ok && waited < 32) begin
      if (s_ready) ok = 1;
      tick();
      waited++;
    end
    s_valid = 1'b0;
    if (ok) exp_q.push_back(d);
    else begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout: got s_ready=0 expected 1 for data %0h", d);
    end
  endtask

  task automatic pulse_sync();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    tick();
    tick();
  endtask

  // Monitor: every change of value must be the next queued sample
  logic [11:0] prev_value;
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      prev_value = value;
    end else if (value !== prev_value) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_value: got %0h expected no change from %0h", value, prev_value);
      end else begin
        check("value_seq", 32'(value), 32'(exp_q.pop_front()));
      end
      prev_value = value;
    end
  end

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_data = '0; rate_div = '0; sync = 1'b0; underrun_clr = 1'b0;

    // Reset
    repeat (3) tick();
    check("rst_value", 32'(value), 32'h800);
    check("rst_level", 32'(level), 0);
    check("rst_ready", 32'(s_ready), 1);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_frame_tick", 32'(frame_tick), 0);
    rst = 1'b1;
    tick();

    // Start threshold
    push(12'h111); push(12'h222); push(12'h333);
    check("level3", 32'(level), 3);
    pulse_sync();
    check("wait_hold", 32'(value), 32'h800);
    push(12'h123);
    tick();
    sync = 1'b1;
    tick();
    check("frame_tick_hi", 32'(frame_tick), 1);
    check("first_value", 32'(value), 32'h111);
    sync = 1'b0;
    tick();
    check("frame_tick_lo", 32'(frame_tick), 0);
    check("level_after_pop", 32'(level), 3);
    tick();

    // Pacing: rate_div=2 steps every third frame, then rate_div=0 every frame
    rate_div = 16'd2;
    pulse_sync(); check("pace_f1", 32'(value), 32'h111);
    pulse_sync(); check("pace_f2", 32'(value), 32'h111);
    pulse_sync(); check("pace_f3", 32'(value), 32'h222);
    pulse_sync(); check("pace_f4", 32'(value), 32'h222);
    rate_div = 16'd0;
    pulse_sync(); check("pace_fast1", 32'(value), 32'h333);
    pulse_sync(); check("pace_fast2", 32'(value), 32'h123);
    check("drained", 32'(level), 0);

    // Underrun, hold until threshold, clear
    pulse_sync();
    check("underrun_hold", 32'(value), 32'h123);
    check("underrun_set", 32'(underrun), 1);
    push(12'h001); push(12'h002); push(12'h003);
    tick();
    pulse_sync();
    check("starved_hold", 32'(value), 32'h123);
    underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
    check("underrun_clr", 32'(underrun), 0);
    push(12'h004);
    tick();
    pulse_sync(); check("resume", 32'(value), 32'h001);
    pulse_sync(); pulse_sync(); pulse_sync();
    check("drain2", 32'(value), 32'h004);
    underrun_clr = 1'b1;
    sync = 1'b1;
    tick();
    underrun_clr = 1'b0;
    sync = 1'b0;
    check("set_wins", 32'(underrun), 1);
    tick(); tick();
    underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;

    // Full FIFO, refill across a boundary, push and pop together
    for (int i = 0; i < 16; i++) push(12'(12'h400 + i));
    check("full_level", 32'(level), 16);
    check("full_ready", 32'(s_ready), 0);
    s_valid = 1'b1; s_data = 12'h5AA; sync = 1'b1;
    tick();
    sync = 1'b0;
    check("full_pop_level", 32'(level), 15);
    check("full_pop_ready", 32'(s_ready), 1);
    tick();
    s_valid = 1'b0;
    exp_q.push_back(12'h5AA);
    check("full_refill", 32'(level), 16);
    check("full_head_out", 32'(value), 32'h400);
    tick();
    pulse_sync();
    s_valid = 1'b1; s_data = 12'h6BB; sync = 1'b1;
    tick();
    s_valid = 1'b0; sync = 1'b0;
    exp_q.push_back(12'h6BB);
    check("push_pop_same", 32'(level), 15);
    tick(); tick();
    for (int i = 0; i < 15; i++) pulse_sync();
    check("order_last", 32'(value), 32'h6BB);
    check("order_empty", 32'(level), 0);

    // Three starvation cycles
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 4; j++) push(12'(12'hA00 + 16 * i + j));
      tick();
      for (int j = 0; j < 5; j++) pulse_sync();
    end
    check("starve3_flag", 32'(underrun), 1);
`ifdef PMODDA4_FEEDER_UNDERRUN_CNT_EN
    check("underrun_cnt3", 32'(underrun_cnt), 3);
`endif

    // Mid-frame reset discards buffered samples
    push(12'h7A1); push(12'h7A2);
    sync = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick();
    sync = 1'b0;
    tick();
    exp_q.delete();
    check("mid_rst_level", 32'(level), 0);
    check("mid_rst_value", 32'(value), 32'h800);
    check("mid_rst_underrun", 32'(underrun), 0);
`ifdef PMODDA4_FEEDER_UNDERRUN_CNT_EN
    check("mid_rst_cnt", 32'(underrun_cnt), 0);
`endif
    rst = 1'b1;
    tick();
    push(12'h9A0); push(12'h9A1); push(12'h9A2); push(12'h9A3);
    tick();
    pulse_sync(); check("post_rst_first", 32'(value), 32'h9A0);
    pulse_sync(); pulse_sync(); pulse_sync();
    check("post_rst_last", 32'(value), 32'h9A3);
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
